// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO, 16-deep or single holding register, with overrun and error tracking
module uart_rx_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pe_in,
  input  logic       fe_in,
  input  logic       bi_in,
  input  logic       pop,
  input  logic       fifo_en,
  input  logic       rx_clr,
  input  logic       ovr_clr,
  input  logic [1:0] trig_lvl,
  output logic [7:0] dout,
  output logic       pe_out,
  output logic       fe_out,
  output logic       bi_out,
  output logic       empty,
  output logic       full,
  output logic [4:0] count,
  output logic       overrun,
  output logic       trigger,
  output logic       err_in_fifo
);

  logic [10:0] mem [16];
  logic [3:0]  wr_ptr, rd_ptr;
  logic [4:0]  cnt, err_cnt, cap, lvl;
  logic        ovr, en_q, en_seen;
  logic        flush, do_push, do_pop, ovr_ev, hold_ovw, inc, dec;
  logic [10:0] head, entry;

  assign cap         = fifo_en ? 5'd16 : 5'd1;
  assign empty       = (cnt == 5'd0);
  assign full        = (cnt == cap);
  assign count       = cnt;
  assign overrun     = ovr;
  assign err_in_fifo = (err_cnt != 5'd0);
  assign entry       = {bi_in, fe_in, pe_in, din};
  assign head        = empty ? 11'd0 : mem[rd_ptr];
  assign {bi_out, fe_out, pe_out, dout} = head;

  always_comb begin
    lvl = 5'd1;
    case (trig_lvl)
      2'b00:   lvl = 5'd1;
      2'b01:   lvl = 5'd4;
      2'b10:   lvl = 5'd8;
      default: lvl = 5'd14;
    endcase
  end

  assign trigger = fifo_en ? (cnt >= lvl) : ~empty;

  // en_seen keeps the first cycle after reset from mistaking an unknown old mode for a change
  assign flush    = rx_clr | (en_seen & (fifo_en != en_q));
  assign ovr_ev   = push & full & ~pop & ~flush;
  assign hold_ovw = ovr_ev & ~fifo_en;
  assign do_pop   = pop & ~empty & ~flush;
  assign do_push  = push & ~flush & (~full | pop);
  assign inc      = do_push & (|entry[10:8]);
  assign dec      = do_pop & (|head[10:8]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= 4'd0;
      rd_ptr  <= 4'd0;
      cnt     <= 5'd0;
      err_cnt <= 5'd0;
      ovr     <= 1'b0;
      en_q    <= 1'b0;
      en_seen <= 1'b0;
    end else begin
      en_seen <= 1'b1;
      en_q    <= fifo_en;
      if (flush) begin
        wr_ptr  <= 4'd0;
        rd_ptr  <= 4'd0;
        cnt     <= 5'd0;
        err_cnt <= 5'd0;
        ovr     <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 4'd1;
        if (do_pop)  rd_ptr <= rd_ptr + 4'd1;
        case ({do_push, do_pop})
          2'b10:   cnt <= cnt + 5'd1;
          2'b01:   cnt <= cnt - 5'd1;
          default: cnt <= cnt;
        endcase
        // an overwrite in holding mode replaces the only entry, so its error state is simply the new one
        if (hold_ovw)
          err_cnt <= {4'd0, |entry[10:8]};
        else if (inc & ~dec)
          err_cnt <= err_cnt + 5'd1;
        else if (dec & ~inc)
          err_cnt <= err_cnt - 5'd1;
        if (ovr_ev)
          ovr <= 1'b1;
        else if (ovr_clr)
          ovr <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= entry;
    else if (hold_ovw)
      mem[rd_ptr] <= entry;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue-based reference model
module tb_uart_rx_fifo;

  logic       clk, rst, push, pe_in, fe_in, bi_in, pop, fifo_en, rx_clr, ovr_clr;
  logic [7:0] din, dout;
  logic [1:0] trig_lvl;
  logic       pe_out, fe_out, bi_out, empty, full, overrun, trigger, err_in_fifo;
  logic [4:0] count;

  int total = 0;
  int bad = 0;

  logic [10:0] q[$];
  logic        m_ovr;
  logic        m_en_q;

  uart_rx_fifo dut (
    .clk(clk), .rst(rst), .push(push), .din(din), .pe_in(pe_in), .fe_in(fe_in),
    .bi_in(bi_in), .pop(pop), .fifo_en(fifo_en), .rx_clr(rx_clr), .ovr_clr(ovr_clr),
    .trig_lvl(trig_lvl), .dout(dout), .pe_out(pe_out), .fe_out(fe_out), .bi_out(bi_out),
    .empty(empty), .full(full), .count(count), .overrun(overrun), .trigger(trigger),
    .err_in_fifo(err_in_fifo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int level(input logic [1:0] t);
    case (t)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 14;
    endcase
  endfunction

  task automatic compare_model();
    int n = q.size();
    int cap = fifo_en ? 16 : 1;
    logic any_err = 1'b0;
    foreach (q[i]) if (q[i][10:8] != 3'd0) any_err = 1'b1;
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == cap));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("trigger", 32'(trigger), 32'(fifo_en ? (n >= level(trig_lvl)) : (n != 0)));
    chk("err_in_fifo", 32'(err_in_fifo), 32'(any_err));
    chk("head", 32'({bi_out, fe_out, pe_out, dout}), 32'(n != 0 ? q[0] : 11'd0));
  endtask

  task automatic model_update();
    int n = q.size();
    int cap = fifo_en ? 16 : 1;
    logic [10:0] e = {bi_in, fe_in, pe_in, din};
    if (rx_clr || (fifo_en != m_en_q)) begin
      q.delete();
      m_ovr = 1'b0;
    end else if (push && n == cap && !pop) begin
      m_ovr = 1'b1;
      if (!fifo_en) begin
        q.delete();
        q.push_back(e);
      end
    end else begin
      if (ovr_clr) m_ovr = 1'b0;
      if (pop && n > 0) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    m_en_q = fifo_en;
  endtask

  // Drive one cycle: apply inputs, check outputs mid-cycle, advance model at the edge.
  task automatic step(input logic p, input logic [7:0] d, input logic [2:0] e,
                      input logic po, input logic c, input logic oc);
    push = p; din = d; {bi_in, fe_in, pe_in} = e; pop = po; rx_clr = c; ovr_clr = oc;
    @(negedge clk);
    compare_model();
    @(posedge clk);
    model_update();
    #1;
    push = 1'b0; pop = 1'b0; rx_clr = 1'b0; ovr_clr = 1'b0;
    {bi_in, fe_in, pe_in} = 3'd0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_trigger"}, 32'(trigger), 32'd0);
    chk({tag, "_err"}, 32'(err_in_fifo), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_head"}, 32'({bi_out, fe_out, pe_out, dout}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; din = 8'd0; pe_in = 1'b0; fe_in = 1'b0; bi_in = 1'b0;
    pop = 1'b0; fifo_en = 1'b1; rx_clr = 1'b0; ovr_clr = 1'b0; trig_lvl = 2'b11;
    m_ovr = 1'b0;
    #12;
    check_reset_state("reset");
    rst = 1'b0;
    m_en_q = fifo_en;
    @(posedge clk); #1;

    // fill 0x41..0x50, trigger at level 14
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(8'h41 + i), 3'd0, 1'b0, 1'b0, 1'b0);
      chk("fill_trigger", 32'(trigger), 32'(i + 1 >= 14));
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);

    // overrun at full, discarded data
    step(1'b1, 8'h99, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(count), 32'd16);
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("pop_order", 32'(dout), 32'(8'h41 + i));
      step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // holding mode overwrite
    fifo_en = 1'b0;
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h11, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("hold_dout", 32'(dout), 32'h22);
    chk("hold_ovr", 32'(overrun), 32'd1);
    chk("hold_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1);
    fifo_en = 1'b1;
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // framing error tracking
    step(1'b1, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h02, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h33, 3'b010, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h04, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("err_set", 32'(err_in_fifo), 32'd1);
    chk("fe_not_head", 32'(fe_out), 32'd0);
    step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("fe_head_dout", 32'(dout), 32'h33);
    chk("fe_head", 32'(fe_out), 32'd1);
    chk("err_still", 32'(err_in_fifo), 32'd1);
    step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("err_gone", 32'(err_in_fifo), 32'd0);
    chk("fe_gone", 32'(fe_out), 32'd0);
    step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);

    // simultaneous push/pop at empty, 5 and full
    step(1'b1, 8'hA0, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("pp_empty", 32'(count), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA1 + i), 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hB0, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("pp_five", 32'(count), 32'd5);
    for (int i = 0; i < 11; i++) step(1'b1, 8'(8'hC0 + i), 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hD0, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("pp_full", 32'(count), 32'd16);
    chk("pp_full_ovr", 32'(overrun), 32'd0);
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);

    // rx_clr with push, then mode-change flush
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i), 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h70, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h80 + i), 3'd0, 1'b0, 1'b0, 1'b0);
    fifo_en = 1'b0;
    #1;
    chk("mode_pre_flush", 32'(count), 32'd3);
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("mode_flush", 32'(count), 32'd0);
    fifo_en = 1'b1;
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // randomized traffic with alternating fill/drain bias
    for (int i = 0; i < 700; i++) begin
      int pp = ((i / 50) % 2 == 0) ? 75 : 30;
      if ($urandom_range(0, 63) == 0) fifo_en = ~fifo_en;
      trig_lvl = 2'($urandom_range(0, 3));
      step($urandom_range(0, 99) < pp, 8'($urandom),
           ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
           $urandom_range(0, 99) < (100 - pp),
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 8);
    end

    // reset mid-operation
    fifo_en = 1'b1;
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hE0 + i), 3'b001, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check_reset_state("midrst");
    q.delete();
    m_ovr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    m_en_q = fifo_en;
    step(1'b1, 8'h5A, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_dout", 32'(dout), 32'h5A);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL use clock clk and reset rst, where rst is asynchronous and active-high.
REQ-002 Port list, one per line (name  direction  width  meaning):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- push  in  1  one-cycle write strobe from receiver
- din  in  8  received character, right-justified
- pe_in  in  1  parity error for din
- fe_in  in  1  framing error for din
- bi_in  in  1  break indication for din
- pop  in  1  one-cycle read strobe from RBR read
- fifo_en  in  1  1 = 16-deep FIFO mode, 0 = single holding register mode
- rx_clr  in  1  one-cycle synchronous flush request
- ovr_clr  in  1  one-cycle clear of overrun (LSR read)
- trig_lvl  in  2  trigger level select: 00=1, 01=4, 10=8, 11=14 entries
- dout  out  8  head-entry character (show-ahead)
- pe_out  out  1  head-entry parity error
- fe_out  out  1  head-entry framing error
- bi_out  out  1  head-entry break
- empty  out  1  no entries stored
- full  out  1  capacity reached
- count  out  5  entries stored, 0..16
- overrun  out  1  sticky overrun flag
- trigger  out  1  count >= selected level
- err_in_fifo  out  1  at least one stored entry has pe, fe or bi set

Function
REQ-003 Each entry SHALL hold 11 bits, {bi, fe, pe, data[7:0]}; storage SHALL be 16 entries with 4-bit wrapping read/write pointers.
REQ-004 Capacity SHALL be 16 when fifo_en=1 and 1 when fifo_en=0; full SHALL equal (count == capacity).
REQ-005 dout/pe_out/fe_out/bi_out SHALL reflect the entry at the read pointer with zero latency (show-ahead); they SHALL read 0 when empty.
REQ-006 A push when not full SHALL write the entry at the write pointer, advance it, and increment count on the next clock edge.
REQ-007 A pop when not empty SHALL advance the read pointer and decrement count; a pop when empty SHALL be ignored with no state change.
REQ-008 Push and pop in the same cycle with 0 < count < capacity SHALL both take effect, leaving count unchanged.
REQ-009 Push and pop in the same cycle when empty SHALL store the push and ignore the pop, so that count becomes 1.
REQ-010 Push and pop in the same cycle when full SHALL perform both operations, leaving count unchanged and overrun unchanged.
REQ-011 A push when full without pop, in FIFO mode, SHALL discard din and set overrun.
REQ-012 A push when full without pop, in holding mode, SHALL overwrite the single entry and set overrun.
REQ-013 overrun SHALL remain set until ovr_clr, rx_clr or rst; if ovr_clr and a new overrun event coincide, overrun SHALL remain 1.
REQ-014 trigger SHALL be combinational from count and trig_lvl; in holding mode trigger SHALL equal ~empty.
REQ-015 An error counter (0..16) SHALL increment on an accepted push carrying any of pe_in/fe_in/bi_in and decrement on an accepted pop of an entry with any error bit set; simultaneous increment and decrement SHALL cancel. err_in_fifo SHALL equal (error counter != 0).
REQ-016 rx_clr SHALL, on the next edge, zero both pointers, count, the error counter and overrun; any push or pop in that same cycle SHALL be discarded. Storage contents need not be cleared.
REQ-017 Any change of fifo_en, detected against a registered copy, SHALL perform the same flush as rx_clr one cycle after the change.
REQ-018 count SHALL never exceed 16 nor underflow below 0 under any input sequence.

Reset
REQ-019 Asserting rst SHALL immediately force the following: pointers=0, count=0, error counter=0, overrun=0, empty=1, full=0, trigger=0, err_in_fifo=0, dout=0, and head error outputs=0.
REQ-020 Reset asserted mid-operation SHALL discard all stored entries; the first push after deassertion SHALL appear at dout with count=1.

Verification
REQ-021 FIFO mode: push 0x41..0x50 (16 entries) -> full=1, count=16, trigger=1 at trig_lvl=11 from count 14; 16 pops return 0x41..0x50 in order, after which empty=1.
REQ-022 FIFO mode, full: push 0x99 -> overrun=1, count stays 16, 0x99 never popped; then ovr_clr -> overrun=0.
REQ-023 Holding mode: push 0x11 then push 0x22 without pop -> dout=0x22, overrun=1, count=1.
REQ-024 Push 0x33 with fe_in=1 among clean entries -> err_in_fifo=1 until that entry is popped, then 0; fe_out=1 exactly while 0x33 is at the head.
REQ-025 Simultaneous push and pop at empty, at count=5 and at full -> count becomes 1, 5 and 16 respectively, with no overrun.
REQ-026 Fill to 7 entries, assert rx_clr together with push -> count=0, empty=1, overrun=0; toggling fifo_en with entries present -> flush occurs one cycle later.
